// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, defaults and baud divider helper
package uart_pkg;

    localparam int unsigned DEFAULT_BAUD       = 9600;
    localparam int unsigned DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Clocks per oversample tick; integer truncation is intentional.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick generator (one-clk enable every DIV clks)
module uart_baud_tick #(
    parameter int unsigned DIV = 651
) (
    input  logic clk,
    input  logic clr_n,
    output logic tick
);

    localparam int unsigned       CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]     LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count 0..DIV-1 and wrap; only reset restarts the phase.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // Divider register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampling UART byte receiver; UART_RX_PARITY_EN adds an even-parity bit and parity_err
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = DEFAULT_BAUD,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int unsigned    DIV      = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned    SW       = $clog2(OVERSAMPLE);
    localparam int unsigned    BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0]  S_MID    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0]  S_LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

    logic tick;
    logic rx_meta_q;
    logic rx_s_q;

    uart_state_e          state_q, state_d;
    logic                 armed_q, armed_d;
    logic [SW-1:0]        s_q, s_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_q, par_bit_d;
    logic                 perr_q, perr_d;
`endif

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .clr_n (clr_n),
        .tick  (tick)
    );

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Next-state logic; a tick that causes a transition does not also advance s.
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        s_d     = s_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d = par_bit_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                s_d = '0;
                // armed needs a high line first, so a stuck-low line cannot retrigger.
                if (armed_q && !rx_s_q) begin
                    state_d = ST_START;
                    armed_d = 1'b0;
                end else if (rx_s_q) begin
                    armed_d = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_q == S_MID) begin
                        s_d     = '0;
                        bit_d   = '0;
                        state_d = rx_s_q ? ST_IDLE : ST_DATA;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        s_d     = '0;
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        par_bit_d = rx_s_q;
                        s_d       = '0;
                        state_d   = ST_STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        state_d = ST_IDLE;
                        armed_d = 1'b0;
                        s_d     = '0;
                        if (rx_s_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        perr_d = (^shift_q) ^ par_bit_q;
`endif
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                armed_d = 1'b0;
                s_d     = '0;
            end
        endcase
    end

    // Receiver state and registered outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            armed_q <= 1'b0;
            s_q     <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            s_q     <= s_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= (state_d != ST_IDLE);
`ifdef UART_RX_PARITY_EN
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign data_out  = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Byte receiver for the UART receiver path; consumes the raw serial line and produces parallel bytes.
- Runs entirely on the system clock and derives 16x-oversample ticks internally.
- Replaces the use of divided clocks as logic clocks with clock-enable ticks.
- Feeds the display/LED stage through a one-cycle valid strobe.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- OVERSAMPLE, 16: ticks per bit; must be even and ≥ 8.
- DATA_BITS, 8: data bits per frame, LSB first.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- rx  in  1  asynchronous serial input; idles high.
- data_out  out  DATA_BITS  last good byte received.
- rx_valid  out  1  one-clk pulse when data_out is updated.
- frame_err  out  1  one-clk pulse when the stop bit is sampled low.
- busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (clr_n=0, async):
  - state=IDLE; synchronizer flops=1; tick divider, sample counter and bit counter=0.
  - data_out=0, rx_valid=0, frame_err=0, busy=0.
- Synchronizer: 2-FF on rx, giving rx_s. All decisions use rx_s, so there are 2 clk of input latency.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer truncation; 100e6/153600 gives 651.
  - tick pulses high for 1 clk every DIV clks; the counter counts 0..DIV-1 and wraps.
  - The counter free-runs and resets only on clr_n.
- State machine; the sample counter s counts ticks 0..OVERSAMPLE-1:
  - IDLE: when armed and rx_s=0, go to START with s=0. armed sets when rx_s=1 is seen in IDLE and clears on leaving IDLE. This blocks retrigger on a held-low line.
  - START: on the tick where s=OVERSAMPLE/2-1 (mid-bit):
    - rx_s=0 → DATA, s=0, bit=0.
    - rx_s=1 → IDLE (glitch rejected; no pulse).
  - DATA: on the tick where s=OVERSAMPLE-1:
    - shift rx_s into shift_reg MSB, shifting right, so the final byte is LSB-first.
    - s=0, bit++.
    - after bit=DATA_BITS-1 is shifted → STOP.
  - STOP: on the tick where s=OVERSAMPLE-1:
    - rx_s=1 → data_out<=shift_reg, rx_valid=1 for the next clk only.
    - rx_s=0 → frame_err=1 for 1 clk; data_out unchanged.
    - In both cases → IDLE with armed=0.
  - In every other cycle, s increments on tick only.
- Latency: rx_valid rises 1 clk after the stop-bit sample tick, about 9.5 bit times plus 2 clk after the start edge at rx.
- rx_valid and frame_err are never high together. There is no back-pressure: a consumer that misses the pulse loses the byte.
- busy is high in START, DATA and STOP.
- Reset mid-frame aborts immediately; no pulse is emitted, even across a following clr_n release.
- A tick coinciding with a state transition is consumed by the transition only.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - a PARITY state sits between DATA and STOP and samples one even-parity bit at s=OVERSAMPLE-1.
  - port parity_err (out, 1) is added; it pulses 1 clk alongside the STOP result if XOR(data, parity bit)≠0.
  - data_out and rx_valid still update on a good stop bit.
- When undefined: no PARITY state, no parity_err port, frame length 1+DATA_BITS+1.

Decomposition:
- Package uart_pkg:
  - state encoding typedef (IDLE, START, DATA, PARITY, STOP).
  - a function computing DIV from CLK_FREQ/BAUD/OVERSAMPLE.
  - default BAUD and OVERSAMPLE constants shared with a future uart_tx.
- Sub-module uart_baud_tick:
  - parameter DIV; ports clk, clr_n, tick.
  - reused by the transmitter.

Test Plan:
- CLK_FREQ=1_600_000, BAUD=10_000 (DIV=10, 160 clk/bit). Frame 0xA5, good stop → data_out=0xA5, rx_valid high exactly 1 clk; busy falls the same cycle.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two rx_valid pulses 1600 clk apart; data_out=0x00 then 0xFF.
- 40-clk low glitch on idle line → return to IDLE; no rx_valid, no frame_err; next valid frame 0x3C received correctly.
- Frame 0x55 with stop bit low, line held low 3 bit times → one frame_err pulse; data_out keeps its previous value; no new frame until the line goes high, then 0x12 received OK.
- clr_n pulsed low mid-DATA during 0x81 → all outputs 0 immediately; the rest of the frame is ignored; the next frame 0x7E yields rx_valid with 0x7E.
- UART_RX_PARITY_EN defined: 0xA5 with parity bit 0 → rx_valid, no parity_err; with parity bit 1 → rx_valid plus parity_err in the same cycle.
